// File: rtl/reorder_buffer.sv
// Reorder buffer: circular buffer of in-flight instructions. Entries are
// allocated at tail in program order, marked ready by any of three writeback
// ports, and retired in order from head to the register file. A jump flush
// discards everything in flight.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif

module reorder_buffer #(
  parameter int WORD_SIZE           = `WORD_SIZE,
  parameter int ROB_ENTRIES         = 8,
  parameter int ROB_ENTRY_WIDTH     = `ROB_ENTRY_WIDTH,
  parameter int ARCH_REG_INDEX_SIZE = `ARCH_REG_INDEX_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           require_rob_entry,
  input  logic [ARCH_REG_INDEX_SIZE-1:0] rd,
  input  logic                           is_store,
  output logic [ROB_ENTRY_WIDTH-1:0]     assigned_rob_id,
  output logic                           full,
  input  logic [ROB_ENTRY_WIDTH-1:0]     s1_rob_id,
  input  logic [ROB_ENTRY_WIDTH-1:0]     s2_rob_id,
  output logic [WORD_SIZE-1:0]           rob_s1_data,
  output logic [WORD_SIZE-1:0]           rob_s2_data,
  output logic                           rob_s1_valid,
  output logic                           rob_s2_valid,
  input  logic                           alu_wb_bypass_enable,
  input  logic [ROB_ENTRY_WIDTH-1:0]     alu_wb_rob_id,
  input  logic [WORD_SIZE-1:0]           alu_wb_data,
  input  logic                           mem_wb_bypass_enable,
  input  logic [ROB_ENTRY_WIDTH-1:0]     mem_wb_rob_id,
  input  logic [WORD_SIZE-1:0]           mem_wb_data,
  input  logic                           mul_wb_bypass_enable,
  input  logic [ROB_ENTRY_WIDTH-1:0]     mul_wb_rob_id,
  input  logic [WORD_SIZE-1:0]           mul_wb_data,
  output logic                           commit,
  output logic [ROB_ENTRY_WIDTH-1:0]     commit_rob_id,
  output logic [ARCH_REG_INDEX_SIZE-1:0] commit_rd,
  output logic [ARCH_REG_INDEX_SIZE-1:0] reg_in,
  output logic [WORD_SIZE-1:0]           din,
  output logic                           wenable_rf,
  input  logic                           jump_taken
);

  localparam int CNT_W = ROB_ENTRY_WIDTH + 1;
  localparam logic [CNT_W-1:0]           CNT_FULL = CNT_W'(ROB_ENTRIES);
  localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
  localparam logic [ROB_ENTRY_WIDTH-1:0] PTR_ONE  = ROB_ENTRY_WIDTH'(1);

  logic [ROB_ENTRIES-1:0]         valid_r;
  logic [ROB_ENTRIES-1:0]         ready_r;
  logic [ROB_ENTRIES-1:0]         store_r;
  logic [ARCH_REG_INDEX_SIZE-1:0] rd_r   [ROB_ENTRIES];
  logic [WORD_SIZE-1:0]           data_r [ROB_ENTRIES];
  logic [ROB_ENTRY_WIDTH-1:0]     head_r;
  logic [ROB_ENTRY_WIDTH-1:0]     tail_r;
  logic [CNT_W-1:0]               count_r;

  logic full_s;
  logic alloc_s;
  logic commit_s;

  // full uses the pre-edge count, so a same-cycle commit never frees a slot early
  assign full_s          = (count_r == CNT_FULL);
  assign full            = full_s;
  assign assigned_rob_id = tail_r;
  assign alloc_s         = require_rob_entry & ~full_s & ~jump_taken;
  // ready is the registered bit, so a writeback landing at head retires next cycle
  assign commit_s        = valid_r[head_r] & ready_r[head_r] & ~jump_taken;

  // Lookups read registered state only; decode does its own bypassing
  assign rob_s1_valid = valid_r[s1_rob_id] & ready_r[s1_rob_id];
  assign rob_s2_valid = valid_r[s2_rob_id] & ready_r[s2_rob_id];
  assign rob_s1_data  = data_r[s1_rob_id];
  assign rob_s2_data  = data_r[s2_rob_id];

  // Retirement outputs: head entry contents when committing, all zero otherwise
  always_comb begin
    commit        = 1'b0;
    commit_rob_id = '0;
    commit_rd     = '0;
    reg_in        = '0;
    din           = '0;
    wenable_rf    = 1'b0;
    if (commit_s) begin
      commit        = 1'b1;
      commit_rob_id = head_r;
      commit_rd     = rd_r[head_r];
      reg_in        = rd_r[head_r];
      din           = data_r[head_r];
      wenable_rf    = ~store_r[head_r] & (rd_r[head_r] != '0);
    end else begin
      commit = 1'b0;
    end
  end

  // Head/tail/count bookkeeping; a flush returns everything to the empty state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (jump_taken) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (alloc_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (commit_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({alloc_s, commit_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Per-entry state: writeback (MEM > MUL > ALU, valid entries only), then
  // retirement clears valid at head, then allocation claims tail
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      ready_r <= '0;
      store_r <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        rd_r[i]   <= '0;
        data_r[i] <= '0;
      end
    end else if (jump_taken) begin
      valid_r <= '0;
      ready_r <= '0;
    end else begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        if (valid_r[i]) begin
          if (mem_wb_bypass_enable && (mem_wb_rob_id == ROB_ENTRY_WIDTH'(i))) begin
            ready_r[i] <= 1'b1;
            data_r[i]  <= mem_wb_data;
          end else if (mul_wb_bypass_enable && (mul_wb_rob_id == ROB_ENTRY_WIDTH'(i))) begin
            ready_r[i] <= 1'b1;
            data_r[i]  <= mul_wb_data;
          end else if (alu_wb_bypass_enable && (alu_wb_rob_id == ROB_ENTRY_WIDTH'(i))) begin
            ready_r[i] <= 1'b1;
            data_r[i]  <= alu_wb_data;
          end
        end
        if (commit_s && (head_r == ROB_ENTRY_WIDTH'(i))) begin
          valid_r[i] <= 1'b0;
        end
        if (alloc_s && (tail_r == ROB_ENTRY_WIDTH'(i))) begin
          valid_r[i] <= 1'b1;
          ready_r[i] <= 1'b0;
          store_r[i] <= is_store;
          rd_r[i]    <= rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based model of in-flight
// instructions.

module tb_reorder_buffer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        require_rob_entry;
  logic [4:0]  rd;
  logic        is_store;
  logic [2:0]  assigned_rob_id;
  logic        full;
  logic [2:0]  s1_rob_id, s2_rob_id;
  logic [31:0] rob_s1_data, rob_s2_data;
  logic        rob_s1_valid, rob_s2_valid;
  logic        alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable;
  logic [2:0]  alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id;
  logic [31:0] alu_wb_data, mem_wb_data, mul_wb_data;
  logic        commit;
  logic [2:0]  commit_rob_id;
  logic [4:0]  commit_rd, reg_in;
  logic [31:0] din;
  logic        wenable_rf;
  logic        jump_taken;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .require_rob_entry(require_rob_entry), .rd(rd), .is_store(is_store),
    .assigned_rob_id(assigned_rob_id), .full(full),
    .s1_rob_id(s1_rob_id), .s2_rob_id(s2_rob_id),
    .rob_s1_data(rob_s1_data), .rob_s2_data(rob_s2_data),
    .rob_s1_valid(rob_s1_valid), .rob_s2_valid(rob_s2_valid),
    .alu_wb_bypass_enable(alu_wb_bypass_enable), .alu_wb_rob_id(alu_wb_rob_id), .alu_wb_data(alu_wb_data),
    .mem_wb_bypass_enable(mem_wb_bypass_enable), .mem_wb_rob_id(mem_wb_rob_id), .mem_wb_data(mem_wb_data),
    .mul_wb_bypass_enable(mul_wb_bypass_enable), .mul_wb_rob_id(mul_wb_rob_id), .mul_wb_data(mul_wb_data),
    .commit(commit), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
    .reg_in(reg_in), .din(din), .wenable_rf(wenable_rf),
    .jump_taken(jump_taken)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered queue of in-flight instructions
  typedef struct {
    int id;
    int rdn;
    bit st;
    bit rdy;
  } ent_t;

  ent_t        q[$];
  int          next_id;
  logic [31:0] mdata [N];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_pos(input int id);
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].id == id) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    next_id = 0;
    for (int i = 0; i < N; i++) mdata[i] = 32'h0;
  endtask

  function automatic bit exp_commit();
    return !jump_taken && (q.size() > 0) && q[0].rdy;
  endfunction

  task automatic compare_all();
    int p1, p2;
    bit ec;
    p1 = find_pos(int'(s1_rob_id));
    p2 = find_pos(int'(s2_rob_id));
    check("full", 64'(full), 64'(q.size() == N));
    check("assigned_id", 64'(assigned_rob_id), 64'(next_id));
    check("s1_valid", 64'(rob_s1_valid), 64'((p1 >= 0) ? q[p1].rdy : 1'b0));
    check("s2_valid", 64'(rob_s2_valid), 64'((p2 >= 0) ? q[p2].rdy : 1'b0));
    check("s1_data", 64'(rob_s1_data), 64'(mdata[s1_rob_id]));
    check("s2_data", 64'(rob_s2_data), 64'(mdata[s2_rob_id]));
    ec = exp_commit();
    check("commit", 64'(commit), 64'(ec));
    if (ec) begin
      check("commit_id", 64'(commit_rob_id), 64'(q[0].id));
      check("commit_rd", 64'(commit_rd), 64'(q[0].rdn));
      check("reg_in", 64'(reg_in), 64'(q[0].rdn));
      check("din", 64'(din), 64'(mdata[q[0].id]));
      check("wenable_rf", 64'(wenable_rf), 64'(!q[0].st && q[0].rdn != 0));
    end else begin
      check("idle_commit_outs", {commit_rob_id, commit_rd, reg_in, din, wenable_rf}, 64'h0);
    end
  endtask

  task automatic apply_wb(input logic [2:0] id, input logic [31:0] d);
    int p;
    p = find_pos(int'(id));
    if (p >= 0) begin
      q[p].rdy = 1'b1;
      mdata[id] = d;
    end
  endtask

  task automatic model_edge();
    bit ec;
    int pre;
    ent_t e;
    if (jump_taken) begin
      q.delete();
      next_id = 0;
      return;
    end
    ec  = exp_commit();
    pre = q.size();
    // later ports overwrite earlier ones: MEM has the final say
    if (alu_wb_bypass_enable) apply_wb(alu_wb_rob_id, alu_wb_data);
    if (mul_wb_bypass_enable) apply_wb(mul_wb_rob_id, mul_wb_data);
    if (mem_wb_bypass_enable) apply_wb(mem_wb_rob_id, mem_wb_data);
    if (ec) void'(q.pop_front());
    if (require_rob_entry && pre < N) begin
      e.id  = next_id;
      e.rdn = int'(rd);
      e.st  = is_store;
      e.rdy = 1'b0;
      q.push_back(e);
      next_id = (next_id + 1) % N;
    end
  endtask

  task automatic clear_in();
    require_rob_entry = 1'b0; rd = 5'd0; is_store = 1'b0;
    s1_rob_id = 3'd0; s2_rob_id = 3'd0;
    alu_wb_bypass_enable = 1'b0; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h0;
    mem_wb_bypass_enable = 1'b0; mem_wb_rob_id = 3'd0; mem_wb_data = 32'h0;
    mul_wb_bypass_enable = 1'b0; mul_wb_rob_id = 3'd0; mul_wb_data = 32'h0;
    jump_taken = 1'b0;
  endtask

  // inputs are set just after a rising edge; outputs are checked before the next one
  task automatic step();
    #2;
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_commit", 64'(commit), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] r, input logic st);
    clear_in();
    require_rob_entry = 1'b1; rd = r; is_store = st;
    step();
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Fill to capacity, then an ignored ninth request
    for (int i = 0; i < N; i++) begin
      clear_in();
      require_rob_entry = 1'b1; rd = 5'(i + 1);
      #1;
      check("alloc_id", 64'(assigned_rob_id), 64'(i));
      step();
    end
    check("full_after_8", 64'(full), 64'h1);
    alloc(5'd9, 1'b0);
    check("tail_hold", 64'(assigned_rob_id), 64'h0);
    check("still_full", 64'(full), 64'h1);

    // Single ALU result retires the cycle after writeback
    do_reset();
    alloc(5'd5, 1'b0);
    clear_in();
    alu_wb_bypass_enable = 1'b1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'hDEADBEEF;
    #1;
    check("no_same_cycle_commit", 64'(commit), 64'h0);
    step();
    clear_in();
    #1;
    check("c31_commit", 64'(commit), 64'h1);
    check("c31_rd", 64'(commit_rd), 64'd5);
    check("c31_din", 64'(din), 64'hDEADBEEF);
    check("c31_wen", 64'(wenable_rf), 64'h1);
    step();
    clear_in();
    #1;
    check("c31_empty_commit", 64'(commit), 64'h0);
    step();

    // Out-of-order completion retires in order
    do_reset();
    alloc(5'd1, 1'b0);
    alloc(5'd2, 1'b0);
    clear_in();
    mul_wb_bypass_enable = 1'b1; mul_wb_rob_id = 3'd1; mul_wb_data = 32'h1111;
    step();
    clear_in();
    #1;
    check("c32_blocked", 64'(commit), 64'h0);
    alu_wb_bypass_enable = 1'b1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h2222;
    step();
    clear_in();
    #1;
    check("c32_first_id", 64'(commit_rob_id), 64'h0);
    step();
    clear_in();
    #1;
    check("c32_second_id", 64'(commit_rob_id), 64'h1);
    check("c32_second_din", 64'(din), 64'h1111);
    step();

    // Stores and rd=0 never write the register file; port priority
    do_reset();
    alloc(5'd3, 1'b1);
    clear_in();
    mem_wb_bypass_enable = 1'b1; mem_wb_rob_id = 3'd0; mem_wb_data = 32'hA5A5A5A5;
    alu_wb_bypass_enable = 1'b1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h0BAD0BAD;
    mul_wb_bypass_enable = 1'b1; mul_wb_rob_id = 3'd0; mul_wb_data = 32'h0BADF00D;
    step();
    clear_in();
    #1;
    check("c33_store_commit", 64'(commit), 64'h1);
    check("c33_store_wen", 64'(wenable_rf), 64'h0);
    check("c33_prio_din", 64'(din), 64'hA5A5A5A5);
    require_rob_entry = 1'b1; rd = 5'd0;
    step();
    clear_in();
    alu_wb_bypass_enable = 1'b1; alu_wb_rob_id = 3'd1; alu_wb_data = 32'h77;
    step();
    clear_in();
    #1;
    check("c33_r0_commit", 64'(commit), 64'h1);
    check("c33_r0_wen", 64'(wenable_rf), 64'h0);
    step();

    // Flush overrides simultaneous allocation and writeback
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i + 10), 1'b0);
    clear_in();
    jump_taken = 1'b1; require_rob_entry = 1'b1; rd = 5'd7;
    alu_wb_bypass_enable = 1'b1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h1234;
    step();
    clear_in();
    s1_rob_id = 3'd0; s2_rob_id = 3'd5;
    #1;
    check("c34_full", 64'(full), 64'h0);
    check("c34_id", 64'(assigned_rob_id), 64'h0);
    check("c34_s1v", 64'(rob_s1_valid), 64'h0);
    check("c34_commit", 64'(commit), 64'h0);
    step();

    // Wrap-around and mid-stream asynchronous reset
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i + 1), 1'b0);
    for (int i = 0; i < 6; i++) begin
      clear_in();
      alu_wb_bypass_enable = 1'b1; alu_wb_rob_id = 3'(i); alu_wb_data = 32'(100 + i);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      clear_in();
      step();
    end
    for (int i = 0; i < 6; i++) begin
      clear_in();
      require_rob_entry = 1'b1; rd = 5'(20 + i);
      #1;
      check("c35_wrap_id", 64'(assigned_rob_id), 64'((6 + i) % N));
      step();
    end
    clear_in();
    mem_wb_bypass_enable = 1'b1; mem_wb_rob_id = 3'd1; mem_wb_data = 32'hC0FFEE01;
    step();
    clear_in();
    s1_rob_id = 3'd1;
    #1;
    check("c35_lookup_v", 64'(rob_s1_valid), 64'h1);
    check("c35_lookup_d", 64'(rob_s1_data), 64'hC0FFEE01);
    do_reset();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      clear_in();
      require_rob_entry    = ($urandom_range(0, 2) != 0);
      rd                   = 5'($urandom_range(0, 31));
      is_store             = ($urandom_range(0, 3) == 0);
      s1_rob_id            = 3'($urandom_range(0, 7));
      s2_rob_id            = 3'($urandom_range(0, 7));
      alu_wb_bypass_enable = $urandom_range(0, 1) != 0;
      alu_wb_rob_id        = 3'($urandom_range(0, 7));
      alu_wb_data          = $urandom;
      mem_wb_bypass_enable = $urandom_range(0, 2) == 0;
      mem_wb_rob_id        = 3'($urandom_range(0, 7));
      mem_wb_data          = $urandom;
      mul_wb_bypass_enable = $urandom_range(0, 2) == 0;
      mul_wb_rob_id        = 3'($urandom_range(0, 7));
      mul_wb_data          = $urandom;
      jump_taken           = ($urandom_range(0, 39) == 0);
      if (c == 300) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default `WORD_SIZE (32), data width; ROB_ENTRIES, default 8 (power of two), entry count; ROB_ENTRY_WIDTH, default `ROB_ENTRY_WIDTH (3) = log2(ROB_ENTRIES); ARCH_REG_INDEX_SIZE, default `ARCH_REG_INDEX_SIZE (5).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 require_rob_entry  in  1  decode requests allocation this cycle.
REQ-006 rd / is_store  in  ARCH_REG_INDEX_SIZE / 1  destination register and store flag of the allocating instruction.
REQ-007 assigned_rob_id  out  ROB_ENTRY_WIDTH  id granted (current tail); full  out  1  no free entry.
REQ-008 s1_rob_id, s2_rob_id  in  ROB_ENTRY_WIDTH  operand lookup ids.
REQ-009 rob_s1_data, rob_s2_data  out  WORD_SIZE; rob_s1_valid, rob_s2_valid  out  1  stored result and ready flag of looked-up entry.
REQ-010 {alu,mem,mul}_wb_bypass_enable  in  1; {alu,mem,mul}_wb_rob_id  in  ROB_ENTRY_WIDTH; {alu,mem,mul}_wb_data  in  WORD_SIZE  three writeback ports.
REQ-011 commit  out  1; commit_rob_id  out  ROB_ENTRY_WIDTH; commit_rd / reg_in  out  ARCH_REG_INDEX_SIZE; din  out  WORD_SIZE; wenable_rf  out  1  in-order retirement to register file.
REQ-012 jump_taken  in  1  flush request.

Function
REQ-013 Storage SHALL be a circular buffer: per entry valid, ready, is_store, rd, data; head, tail pointers and a count of 0..ROB_ENTRIES.
REQ-014 full SHALL equal (count == ROB_ENTRIES), combinational from registered state.
REQ-015 assigned_rob_id SHALL equal tail combinationally.
REQ-016 On a rising edge with require_rob_entry=1, full=0, jump_taken=0: entry[tail] gets valid=1, ready=0, rd, is_store; tail increments modulo ROB_ENTRIES.
REQ-017 require_rob_entry while full SHALL be ignored; full is evaluated on pre-edge count, so a commit in the same cycle does not permit allocation.
REQ-018 Writeback on any enabled port SHALL, at the edge, set ready=1 and store data for that id only if the entry is valid; writebacks to invalid entries are dropped.
REQ-019 Multiple ports hitting the same id in one cycle SHALL resolve MEM > MUL > ALU.
REQ-020 Lookup outputs SHALL be combinational from registered state only: rob_sX_valid = valid & ready of entry; same-cycle writebacks are not forwarded (decode handles bypass); data = stored data.
REQ-021 commit SHALL be 1 combinationally when entry[head] is valid and ready and jump_taken=0; then commit_rob_id=head, commit_rd=reg_in=entry rd, din=entry data, wenable_rf = ~is_store & (rd != 0).
REQ-022 When commit=1, at the edge entry[head].valid clears and head increments modulo ROB_ENTRIES; at most one commit per cycle.
REQ-023 When commit=0 all commit outputs SHALL be 0.
REQ-024 Count update: +1 on allocate only, -1 on commit only, unchanged on both or neither.
REQ-025 An entry whose writeback arrives in the same cycle it reaches head SHALL commit the following cycle, not the same cycle.
REQ-026 jump_taken=1 SHALL, at the edge, clear every valid and ready bit and set head=tail=count=0; it overrides allocation, writeback and commit in that cycle.
REQ-027 Pointers SHALL wrap from ROB_ENTRIES-1 to 0 with no bubble.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) clear all valid/ready bits, head, tail, count; full=0, assigned_rob_id=0, commit=0, wenable_rf=0, all data outputs 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries; after release the first allocation receives id 0.

Verification
REQ-030 Reset, then 8 allocations (rd=1..8) -> ids 0..7 granted, full=1 after 8th; 9th request ignored, tail stays 0.
REQ-031 Alloc id0 rd=5, ALU writeback id0 data=0xDEADBEEF -> next cycle commit=1, commit_rd=5, din=0xDEADBEEF, wenable_rf=1; following cycle count=0.
REQ-032 Alloc id0, id1; writeback id1 first then id0 -> id0 commits before id1, one per cycle, in order.
REQ-033 Alloc store (is_store=1, rd=3), MEM writeback -> commit=1, wenable_rf=0; rd=0 ALU instruction -> commit=1, wenable_rf=0.
REQ-034 Fill 6 entries, jump_taken=1 with simultaneous alloc and writeback -> next cycle count=0, full=0, assigned_rob_id=0, all lookups valid=0, no commit.
REQ-035 Commit 6 entries, allocate 6 more -> ids wrap 6,7,0,1,..., lookup of id 1 returns its new data; rst=0 mid-stream -> outputs clear without clock edge.
